// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI4 read/write channel arbiters.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package axi_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int TCO_DEFAULT = 1;

  // Ownership phases: IDLE (no grant), BURST (AW/W in flight), RESP (waiting for B).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // One-hot decode of a master index into a grant vector.
  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_MASTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin selector: first requester scanning from prio upward with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on the pick.
// Ports:
//   req[3:0]  in   request vector, bit n = master n
//   prio[1:0] in   index that gets first look this round
//   valid     out  at least one request present
//   idx[1:0]  out  selected master (0 when valid is low)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] prio,
  output logic       valid,
  output logic [1:0] idx
);

  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] k;

  always_comb begin
    rot = '0;
    off = '0;
    k   = '0;
    // rot[i] is the request that sits i places after prio (mod 4)
    for (int i = 0; i < 4; i++) begin
      k      = prio + 2'(i);
      rot[i] = req[k];
    end
    // lowest set rotated bit wins, so scan from the top down
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
  end

  assign valid = |req;
  assign idx   = valid ? (prio + off) : 2'd0;

endmodule

// File: rtl/axi_arbiter_w.sv
// AXI4 write-channel arbiter: one master owns AW/W/B from grant to B handshake, then priority rotates.
// Latency: request sampled in IDLE -> grant next cycle; B handshake -> grant drops next cycle, one idle bubble.
// Backpressure: ownership held indefinitely while AW, last W beat or B handshake is stalled.
// Ports:
//   ACLK, ARESET                  clock, async active-high reset
//   m0_AWVALID..m3_AWVALID        write requests from each master
//   m_AWVALID/m_AWREADY           muxed AW handshake of the granted master
//   m_WVALID/m_WREADY/m_WLAST     muxed W handshake and last-beat marker
//   m_BVALID/m_BREADY             muxed B handshake
//   m0_wgrnt..m3_wgrnt            one-hot write grants (registered)
//   w_busy                        high while any master owns the write path (registered)
module axi_arbiter_w
  import axi_arb_pkg::*;
#(
  parameter int TCO = TCO_DEFAULT
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic m2_AWVALID,
  input  logic m3_AWVALID,
  input  logic m_AWREADY,
  input  logic m_AWVALID,
  input  logic m_WVALID,
  input  logic m_WREADY,
  input  logic m_WLAST,
  input  logic m_BVALID,
  input  logic m_BREADY,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic m2_wgrnt,
  output logic m3_wgrnt,
  output logic w_busy
);

  // TCO only shapes simulation timing in the legacy flow; it has no effect on this logic.
  logic unused_tco;
  assign unused_tco = ^TCO;

  arb_state_e             state;
  logic [1:0]             owner;
  logic [1:0]             prio;
  logic                   aw_done;
  logic                   w_done;
  logic [NUM_MASTERS-1:0] grnt_q;
  logic                   busy_q;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_vld;
  logic [1:0]             pick_idx;

  logic aw_hs;
  logic wlast_hs;
  logic b_hs;
  logic aw_done_nxt;
  logic w_done_nxt;

  assign req = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};

  rr_pick4 u_pick (
    .req   (req),
    .prio  (prio),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign aw_hs    = m_AWVALID && m_AWREADY;
  assign wlast_hs = m_WVALID && m_WREADY && m_WLAST;
  assign b_hs     = m_BVALID && m_BREADY;

  // Include this cycle's handshakes so a same-cycle AW + WLAST goes straight to RESP.
  assign aw_done_nxt = aw_done || aw_hs;
  assign w_done_nxt  = w_done || wlast_hs;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      owner   <= 2'd0;
      prio    <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      grnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= BURST;
            owner   <= pick_idx;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            grnt_q  <= idx_to_onehot(pick_idx);
            busy_q  <= 1'b1;
          end
        end
        BURST: begin
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            state  <= IDLE;
            prio   <= owner + 2'd1;
            grnt_q <= '0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          // unreachable encoding: drop ownership cleanly
          state  <= IDLE;
          grnt_q <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign m0_wgrnt = grnt_q[0];
  assign m1_wgrnt = grnt_q[1];
  assign m2_wgrnt = grnt_q[2];
  assign m3_wgrnt = grnt_q[3];
  assign w_busy   = busy_q;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Self-checking bench for axi_arbiter_w against a transaction-level reference model.
// Latency: model predicts grant/busy for every cycle.
// Backpressure: stalls on AW, W and B are exercised directed and at random.
module tb_axi_arbiter_w;

  logic ACLK;
  logic ARESET;
  logic [3:0] req;
  logic m_AWREADY, m_AWVALID, m_WVALID, m_WREADY, m_WLAST, m_BVALID, m_BREADY;
  logic m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt, w_busy;
  logic [3:0] gnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: owner = -1 means nobody holds the write path
  int mo_owner = -1;
  int mo_prio  = 0;
  bit mo_addr_ok, mo_data_ok, mo_wait_b;

  logic [3:0] prev_gnt = '0;
  int order_q[$];
  logic [3:0] pend;
  int done_m;

  axi_arbiter_w #(.TCO(1)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .m0_AWVALID (req[0]),
    .m1_AWVALID (req[1]),
    .m2_AWVALID (req[2]),
    .m3_AWVALID (req[3]),
    .m_AWREADY  (m_AWREADY),
    .m_AWVALID  (m_AWVALID),
    .m_WVALID   (m_WVALID),
    .m_WREADY   (m_WREADY),
    .m_WLAST    (m_WLAST),
    .m_BVALID   (m_BVALID),
    .m_BREADY   (m_BREADY),
    .m0_wgrnt   (m0_wgrnt),
    .m1_wgrnt   (m1_wgrnt),
    .m2_wgrnt   (m2_wgrnt),
    .m3_wgrnt   (m3_wgrnt),
    .w_busy     (w_busy)
  );

  assign gnt = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_grant();
    if (mo_owner < 0) return 4'b0000;
    return 4'(1 << mo_owner);
  endfunction

  task automatic drive_zero();
    req = '0;
    {m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_WLAST, m_BVALID, m_BREADY} = '0;
  endtask

  // One clock: check outputs, apply inputs, advance the model at the rising edge.
  task automatic step(input logic [3:0] r, input logic awv, input logic awr, input logic wv,
                      input logic wr, input logic wl, input logic bv, input logic br,
                      output int done);
    int gi;
    done = -1;
    @(negedge ACLK);
    chk("grant", {28'd0, gnt}, {28'd0, model_grant()});
    chk("busy", {31'd0, w_busy}, {31'd0, (mo_owner >= 0)});
    if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
      order_q.push_back(gi);
    end
    prev_gnt = gnt;
    req = r;
    m_AWVALID = awv; m_AWREADY = awr;
    m_WVALID = wv; m_WREADY = wr; m_WLAST = wl;
    m_BVALID = bv; m_BREADY = br;
    @(posedge ACLK);
    if (mo_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (mo_owner < 0 && r[(mo_prio + k) % 4]) mo_owner = (mo_prio + k) % 4;
      end
      mo_addr_ok = 0; mo_data_ok = 0; mo_wait_b = 0;
    end else if (!mo_wait_b) begin
      if (awv && awr) mo_addr_ok = 1;
      if (wv && wr && wl) mo_data_ok = 1;
      if (mo_addr_ok && mo_data_ok) mo_wait_b = 1;
    end else if (bv && br) begin
      done     = mo_owner;
      mo_prio  = (mo_owner + 1) % 4;
      mo_owner = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("rst_grant", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, w_busy}, 32'd0);
    mo_owner = -1; mo_prio = 0;
    mo_addr_ok = 0; mo_data_ok = 0; mo_wait_b = 0;
    drive_zero();
    prev_gnt = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic expect_first(input string tag, input int exp_idx);
    chk({tag, "_seen"}, (order_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (order_q.size() > 0) chk(tag, order_q[0], exp_idx);
  endtask

  initial begin
    ARESET = 1'b1;
    drive_zero();
    pend = '0;
    #1;
    chk("por_grant", {28'd0, gnt}, 32'd0);
    chk("por_busy", {31'd0, w_busy}, 32'd0);
    do_reset();

    // idle: no requests, random channel noise must not grant
    for (int i = 0; i < 20; i++)
      step(4'b0000, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), done_m);
    order_q.delete();
    step(4'b1111, 1, 1, 1, 1, 1, 1, 1, done_m);
    step(4'b1111, 1, 1, 1, 1, 1, 1, 1, done_m);
    expect_first("idle_prio", 0);
    repeat (3) step(4'b0000, 1, 1, 1, 1, 1, 1, 1, done_m);

    // single request from m2: AW, later WLAST, later B
    do_reset();
    step(4'b0100, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b0100, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b0100, 1, 1, 0, 0, 0, 0, 0, done_m);
    step(4'b0100, 0, 0, 1, 1, 0, 0, 0, done_m);
    step(4'b0100, 0, 0, 1, 1, 1, 0, 0, done_m);
    step(4'b0100, 0, 0, 0, 0, 0, 1, 0, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0, done_m);
    order_q.delete();
    step(4'b1111, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b1111, 1, 1, 1, 1, 1, 1, 1, done_m);
    expect_first("prio_after_m2", 3);
    repeat (3) step(4'b0000, 1, 1, 1, 1, 1, 1, 1, done_m);

    // round-robin with every handshake immediate
    do_reset();
    order_q.delete();
    for (int i = 0; i < 18; i++) step(4'b1111, 1, 1, 1, 1, 1, 1, 1, done_m);
    chk("rr_count", (order_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (order_q.size() >= 5) begin
      chk("rr0", order_q[0], 0);
      chk("rr1", order_q[1], 1);
      chk("rr2", order_q[2], 2);
      chk("rr3", order_q[3], 3);
      chk("rr4", order_q[4], 0);
    end

    // W completes before AW; B offered throughout so early RESP would release early
    do_reset();
    step(4'b0001, 0, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0001, 0, 0, 1, 1, 1, 1, 1, done_m);
    step(4'b0001, 0, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0001, 1, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0001, 1, 1, 0, 0, 0, 1, 1, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0, done_m);

    // B back-pressure for 5 cycles
    do_reset();
    step(4'b0010, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b0010, 1, 1, 1, 1, 1, 0, 0, done_m);
    for (int i = 0; i < 5; i++) step(4'b0000, 0, 0, 0, 0, 0, 1, 0, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 1, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0, done_m);

    // reset in the middle of m1's burst, then m3 and m1 compete
    do_reset();
    step(4'b0010, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b0010, 1, 1, 0, 0, 0, 0, 0, done_m);
    step(4'b0010, 0, 0, 0, 0, 0, 0, 0, done_m);
    do_reset();
    order_q.delete();
    step(4'b1010, 0, 0, 0, 0, 0, 0, 0, done_m);
    step(4'b1010, 0, 0, 0, 0, 0, 0, 0, done_m);
    expect_first("post_rst_pick", 1);
    step(4'b1010, 1, 1, 1, 1, 1, 1, 1, done_m);

    // randomized traffic with persistent requesters
    do_reset();
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) begin
        do_reset();
        pend = '0;
      end
      for (int i = 0; i < 4; i++) if (!pend[i] && ($urandom % 6 == 0)) pend[i] = 1'b1;
      step(pend, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom % 3 != 0), done_m);
      if (done_m >= 0) pend[done_m] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
